sdram_read: RTL and testbench
=============================

SDRAM_READ -- requirements
Module: sdram_read

Interface
REQ-001 SHALL have port sys_clk, input, 1 bit: 100 MHz system clock; all logic on rising edge.
REQ-002 SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port init_end, input, 1 bit: SDRAM initialisation complete.
REQ-004 SHALL have port rd_en, input, 1 bit: read request, level.
REQ-005 SHALL have port rd_addr, input, 24 bits: {bank[23:22], row[21:9], col[8:0]}.
REQ-006 SHALL have port rd_burst_len, input, 10 bits: words to read; legal range 1..512.
REQ-007 SHALL have port rd_data_in, input, 16 bits: SDRAM DQ bus.
REQ-008 SHALL have port rd_ack, output, 1 bit: rd_sdram_data valid this cycle.
REQ-009 SHALL have port rd_end, output, 1 bit: one-cycle burst-complete pulse.
REQ-010 SHALL have port read_cmd, output, 4 bits: {CS_n,RAS_n,CAS_n,WE_n}, registered.
REQ-011 SHALL have port read_ba, output, 2 bits: bank address, registered.
REQ-012 SHALL have port read_addr, output, 13 bits: row/column/A10, registered.
REQ-013 SHALL have port rd_sdram_data, output, 16 bits: read word; 0 when rd_ack=0.

Function
REQ-014 SHALL use commands NOP=0111, ACTIVE=0011, READ=0101, B_STOP=0110, P_CHARGE=0010.
REQ-015 SHALL use parameters TRCD_CLK=2, TRP_CLK=2, CL_CLK=3 (CAS latency), overridable.
REQ-016 SHALL implement states IDLE, ACTIVE, TRCD, READ, DATA, PRE, TRP, END.
REQ-017 Transitions SHALL be: IDLE->ACTIVE when rd_en&&init_end; ACTIVE->TRCD; TRCD->READ at cnt==TRCD_CLK; READ->DATA; DATA->PRE at cnt==rd_len+CL_CLK-1; PRE->TRP; TRP->END at cnt==TRP_CLK; END->IDLE.
REQ-018 rd_addr and rd_burst_len SHALL be latched (rd_len) on the IDLE->ACTIVE edge; later input changes ignored until the next burst.
REQ-019 A 10-bit cnt SHALL clear in IDLE, READ and END, and on each state-exit condition; it SHALL otherwise increment.
REQ-020 Command register SHALL output, one cycle after the state: ACTIVE -> ACTIVE, ba=bank, addr=row; READ -> READ, ba=bank, addr={4'b0000,col}; PRE -> P_CHARGE, ba=bank, addr=13'h0400; DATA at cnt==rd_len-1 -> B_STOP; all else NOP, ba=2'b11, addr=13'h1fff.
REQ-021 Read word i (0-based) SHALL be sampled from rd_data_in at DATA cnt==CL_CLK+i; rd_ack SHALL be high exactly for cnt in [CL_CLK, CL_CLK+rd_len-1], i.e. rd_len consecutive cycles.
REQ-022 rd_sdram_data SHALL equal the sampled word while rd_ack=1, else 16'd0.
REQ-023 rd_end SHALL be 1 exactly while state==END.
REQ-024 Column wrap inside the page SHALL follow SDRAM full-page mode; the block performs no address increment.
REQ-025 rd_burst_len=0 SHALL be treated as 1.
REQ-026 rd_en while init_end=0 SHALL be ignored; state stays IDLE.

Reset
REQ-027 On sys_rst=1 at a clock edge: state=IDLE, cnt=0, read_cmd=NOP, read_ba=2'b11, read_addr=13'h1fff, rd_ack=0, rd_end=0, rd_sdram_data=0.
REQ-028 Reset mid-burst SHALL abort immediately with no PRE issued; the next request starts with a fresh ACTIVE.

Configuration
REQ-029 Macro SDRAM_RD_DQ_REG_EN defined: rd_data_in SHALL pass through one input register; rd_ack window and DATA exit SHALL shift +1 cycle (CL_CLK+1 effective); B_STOP timing unchanged.
REQ-030 Macro undefined: rd_data_in SHALL be sampled directly per REQ-021.

Structure
REQ-031 Command encodings, TRCD/TRP/CL defaults and state encodings SHALL live in shared package sdram_pkg, also used by the write, init and refresh blocks.
REQ-032 No sub-module; counter, FSM and command register SHALL be inline.

Verification
REQ-033 Reset with rd_en=1, init_end=0 for 20 cycles -> state IDLE, read_cmd=0111, no rd_ack.
REQ-034 rd_addr=24'h8_0A05, len=4, CL=3 -> ACTIVE ba=2 row=0x005; READ col=0x005; B_STOP 4 cycles after READ; rd_ack high 4 cycles starting 4 cycles after READ; rd_end pulse once.
REQ-035 DQ model returning 16'hA000+i, len=512 -> 512 words in order, rd_ack never drops, P_CHARGE addr=13'h0400.
REQ-036 len=0 -> exactly one word, rd_ack high for 1 cycle.
REQ-037 sys_rst asserted at DATA cnt==2 -> next cycle read_cmd=NOP, rd_ack=0; following request reissues ACTIVE.
REQ-038 SDRAM_RD_DQ_REG_EN defined, len=4 -> rd_ack window one cycle later than REQ-034; data identical.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, timing defaults,
// read-FSM state encoding and the {bank,row,col} address layout.
package sdram_pkg;

  // {CS_n, RAS_n, CAS_n, WE_n}
  localparam logic [3:0] CMD_NOP      = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE   = 4'b0011;
  localparam logic [3:0] CMD_READ     = 4'b0101;
  localparam logic [3:0] CMD_B_STOP   = 4'b0110;
  localparam logic [3:0] CMD_P_CHARGE = 4'b0010;

  localparam int TRCD_CLK_DEF = 2;
  localparam int TRP_CLK_DEF  = 2;
  localparam int CL_CLK_DEF   = 3;

  localparam logic [1:0]  BA_IDLE      = 2'b11;
  localparam logic [12:0] ADDR_IDLE    = 13'h1fff;
  localparam logic [12:0] ADDR_PRE_ALL = 13'h0400;  // A10 high: precharge all banks

  typedef enum logic [2:0] {
    RD_IDLE,
    RD_ACTIVE,
    RD_TRCD,
    RD_READ,
    RD_DATA,
    RD_PRE,
    RD_TRP,
    RD_END
  } rd_state_e;

  typedef struct packed {
    logic [1:0]  bank;
    logic [12:0] row;
    logic [8:0]  col;
  } sdram_addr_t;

  // A zero-length request still returns one word.
  function automatic logic [9:0] eff_burst_len(input logic [9:0] len);
    return (len == 10'd0) ? 10'd1 : len;
  endfunction

  function automatic logic [12:0] col_to_addr(input logic [8:0] col);
    return {4'b0000, col};
  endfunction

endpackage

// File: rtl/sdram_read.sv
// SDRAM full-page burst read: ACTIVE, READ, burst-stop, precharge-all.
// Define SDRAM_RD_DQ_REG_EN to add an input register on the DQ bus.
module sdram_read
  import sdram_pkg::*;
#(
  parameter int TRCD_CLK = TRCD_CLK_DEF,
  parameter int TRP_CLK  = TRP_CLK_DEF,
  parameter int CL_CLK   = CL_CLK_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end,
  input  logic        rd_en,
  input  logic [23:0] rd_addr,
  input  logic [9:0]  rd_burst_len,
  input  logic [15:0] rd_data_in,
  output logic        rd_ack,
  output logic        rd_end,
  output logic [3:0]  read_cmd,
  output logic [1:0]  read_ba,
  output logic [12:0] read_addr,
  output logic [15:0] rd_sdram_data
);

`ifdef SDRAM_RD_DQ_REG_EN
  localparam int CL_EFF = CL_CLK + 1;
`else
  localparam int CL_EFF = CL_CLK;
`endif

  localparam logic [9:0] TRCD_C = 10'(TRCD_CLK);
  localparam logic [9:0] TRP_C  = 10'(TRP_CLK);
  localparam logic [9:0] CL_C   = 10'(CL_EFF);

  rd_state_e   state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  sdram_addr_t addr_q;
  logic [9:0]  len_q;
  logic [3:0]  read_cmd_q;
  logic [1:0]  read_ba_q;
  logic [12:0] read_addr_q;
  logic        rd_ack_q;
  logic [15:0] rd_data_q;
  logic [15:0] dq_src;
  logic [9:0]  data_last;
  logic        in_window;

  assign data_last = len_q + CL_C - 10'd1;
  assign in_window = (state_q == RD_DATA) && (cnt_q >= CL_C) && (cnt_q <= data_last);

`ifdef SDRAM_RD_DQ_REG_EN
  logic [15:0] dq_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) dq_q <= 16'h0;
    else         dq_q <= rd_data_in;
  end

  assign dq_src = dq_q;
`else
  assign dq_src = rd_data_in;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE:   if (rd_en && init_end) state_d = RD_ACTIVE;
      RD_ACTIVE: state_d = RD_TRCD;
      RD_TRCD:   if (cnt_q == TRCD_C) state_d = RD_READ;
      RD_READ:   state_d = RD_DATA;
      RD_DATA:   if (cnt_q == data_last) state_d = RD_PRE;
      RD_PRE:    state_d = RD_TRP;
      RD_TRP:    if (cnt_q == TRP_C) state_d = RD_END;
      RD_END:    state_d = RD_IDLE;
      default:   state_d = RD_IDLE;
    endcase
  end

  // The counter restarts on every state change so each wait measures from its own entry.
  always_comb begin
    cnt_d = cnt_q + 10'd1;
    if (state_q == RD_IDLE || state_q == RD_READ || state_q == RD_END || state_d != state_q)
      cnt_d = 10'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= RD_IDLE;
      cnt_q       <= 10'd0;
      addr_q      <= '0;
      len_q       <= 10'd1;
      read_cmd_q  <= CMD_NOP;
      read_ba_q   <= BA_IDLE;
      read_addr_q <= ADDR_IDLE;
      rd_ack_q    <= 1'b0;
      rd_data_q   <= 16'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;

      if (state_q == RD_IDLE && state_d == RD_ACTIVE) begin
        addr_q <= rd_addr;
        len_q  <= eff_burst_len(rd_burst_len);
      end

      read_cmd_q  <= CMD_NOP;
      read_ba_q   <= BA_IDLE;
      read_addr_q <= ADDR_IDLE;
      case (state_q)
        RD_ACTIVE: begin
          read_cmd_q  <= CMD_ACTIVE;
          read_ba_q   <= addr_q.bank;
          read_addr_q <= addr_q.row;
        end
        RD_READ: begin
          read_cmd_q  <= CMD_READ;
          read_ba_q   <= addr_q.bank;
          read_addr_q <= col_to_addr(addr_q.col);
        end
        RD_PRE: begin
          read_cmd_q  <= CMD_P_CHARGE;
          read_ba_q   <= addr_q.bank;
          read_addr_q <= ADDR_PRE_ALL;
        end
        RD_DATA: if (cnt_q == len_q - 10'd1) read_cmd_q <= CMD_B_STOP;
        default: ;
      endcase

      rd_ack_q  <= in_window;
      rd_data_q <= in_window ? dq_src : 16'h0;
    end
  end

  assign read_cmd      = read_cmd_q;
  assign read_ba       = read_ba_q;
  assign read_addr     = read_addr_q;
  assign rd_ack        = rd_ack_q;
  assign rd_sdram_data = rd_data_q;
  assign rd_end        = (state_q == RD_END);

endmodule

// File: tb/tb_sdram_read.sv
// Scoreboard bench for sdram_read: stimulus queues expected commands/words,
// a negedge monitor compares them; a simple CL=3 DQ model feeds data.
module tb_sdram_read;
  import sdram_pkg::*;

`ifdef SDRAM_RD_DQ_REG_EN
  localparam int CL_EFF = 4;
`else
  localparam int CL_EFF = 3;
`endif
  localparam int DEV_CL = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_end;
  logic        rd_en;
  logic [23:0] rd_addr;
  logic [9:0]  rd_burst_len;
  logic [15:0] rd_data_in = 16'hDEAD;
  logic        rd_ack;
  logic        rd_end;
  logic [3:0]  read_cmd;
  logic [1:0]  read_ba;
  logic [12:0] read_addr;
  logic [15:0] rd_sdram_data;

  sdram_read dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .init_end     (init_end),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_burst_len (rd_burst_len),
    .rd_data_in   (rd_data_in),
    .rd_ack       (rd_ack),
    .rd_end       (rd_end),
    .read_cmd     (read_cmd),
    .read_ba      (read_ba),
    .read_addr    (read_addr),
    .rd_sdram_data(rd_sdram_data)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    int          off;
    string       name;
  } cmd_exp_t;

  typedef struct {
    logic [15:0] data;
    int          off;
  } data_exp_t;

  cmd_exp_t  exp_cmd[$];
  data_exp_t exp_data[$];
  int        exp_end[$];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int act_cyc = 0;
  int m       = 0;
  int cur_len = 0;
  logic [15:0] cur_base = 16'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge sys_clk) cyc++;

  // DQ model: word i appears DEV_CL cycles after the READ command is sampled.
  always @(posedge sys_clk) begin
    if (read_cmd == CMD_READ) m = 1;
    else if (m > 0 && m < 4096) m = m + 1;
    #1;
    if (m >= DEV_CL && (m - DEV_CL) < cur_len) rd_data_in = cur_base + 16'(m - DEV_CL);
    else rd_data_in = 16'hDEAD;
  end

  // Monitor: offsets are measured from the cycle ACTIVE appears on the bus.
  always @(negedge sys_clk) begin
    cmd_exp_t  ce;
    data_exp_t de;
    int        eo;
    if (!sys_rst) begin
      if (read_cmd != CMD_NOP) begin
        if (exp_cmd.size() == 0) check("cmd_unexpected", 64'(read_cmd), 64'(CMD_NOP));
        else begin
          ce = exp_cmd.pop_front();
          if (read_cmd == CMD_ACTIVE) act_cyc = cyc;
          check(ce.name, 64'({read_cmd, read_ba, read_addr, 16'(cyc - act_cyc)}),
                64'({ce.cmd, ce.ba, ce.addr, 16'(ce.off)}));
        end
      end
      if (rd_ack) begin
        if (exp_data.size() == 0) check("ack_unexpected", 64'(rd_ack), 64'(0));
        else begin
          de = exp_data.pop_front();
          check("rd_word", 64'({rd_sdram_data, 16'(cyc - act_cyc)}), 64'({de.data, 16'(de.off)}));
        end
      end else begin
        check("data_zero_no_ack", 64'(rd_sdram_data), 64'(0));
      end
      if (rd_end) begin
        if (exp_end.size() == 0) check("rd_end_unexpected", 64'(rd_end), 64'(0));
        else begin
          eo = exp_end.pop_front();
          check("rd_end_time", 64'(cyc - act_cyc), 64'(eo));
        end
      end
    end
  end

  task automatic wait_end();
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sys_clk);
      if (rd_end) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("burst_timeout", 64'(0), 64'(1));
    @(posedge sys_clk);
  endtask

  task automatic run_burst(input logic [23:0] addr, input logic [9:0] len, input int elen,
                           input logic [15:0] base, input logic [1:0] ba,
                           input logic [12:0] row, input logic [12:0] col_addr,
                           input bit wait_done);
    exp_cmd.push_back('{CMD_ACTIVE, ba, row, 0, "cmd_active"});
    exp_cmd.push_back('{CMD_READ, ba, col_addr, 4, "cmd_read"});
    exp_cmd.push_back('{CMD_B_STOP, 2'b11, 13'h1fff, 4 + elen, "cmd_bstop"});
    exp_cmd.push_back('{CMD_P_CHARGE, ba, 13'h0400, elen + CL_EFF + 5, "cmd_precharge"});
    for (int i = 0; i < elen; i++) exp_data.push_back('{base + 16'(i), CL_EFF + 5 + i});
    exp_end.push_back(elen + CL_EFF + 8);
    cur_base = base;
    cur_len  = elen;
    @(posedge sys_clk);
    #1;
    rd_addr      = addr;
    rd_burst_len = len;
    rd_en        = 1'b1;
    @(posedge sys_clk);
    #1;
    // Changes after the request edge must not affect the running burst.
    rd_en        = 1'b0;
    rd_addr      = ~addr;
    rd_burst_len = 10'd7;
    if (wait_done) wait_end();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen_rd;
    sys_rst      = 1'b1;
    init_end     = 1'b0;
    rd_en        = 1'b1;
    rd_addr      = 24'h0;
    rd_burst_len = 10'd0;

    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_values",
          64'({read_cmd, read_ba, read_addr, rd_ack, rd_end, rd_sdram_data}),
          64'({4'b0111, 2'b11, 13'h1fff, 1'b0, 1'b0, 16'h0000}));
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;

    // Requests are ignored until initialisation completes.
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      check("no_init_idle", 64'({read_cmd, rd_ack, rd_end}), 64'({4'b0111, 1'b0, 1'b0}));
    end
    #1;
    rd_en    = 1'b0;
    init_end = 1'b1;

    // bank 2, row 0x005, col 0x005, four words
    run_burst(24'h800A05, 10'd4, 4, 16'h1000, 2'd2, 13'h0005, 13'h0005, 1'b1);
    // bank 1, row 0x1ABC, col 0, full page
    run_burst(24'h757800, 10'd512, 512, 16'hA000, 2'd1, 13'h1ABC, 13'h0000, 1'b1);
    // length 0 behaves as 1; all-ones address
    run_burst(24'hFFFFFF, 10'd0, 1, 16'h5500, 2'd3, 13'h1fff, 13'h01ff, 1'b1);

    // Reset during DATA with cnt==2 aborts without a precharge.
    run_burst(24'h024645, 10'd4, 4, 16'h7700, 2'd0, 13'h0123, 13'h0045, 1'b0);
    seen_rd = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge sys_clk);
      if (read_cmd == CMD_READ) begin
        seen_rd = 1'b1;
        break;
      end
    end
    if (!seen_rd) check("abort_read_timeout", 64'(0), 64'(1));
    @(posedge sys_clk);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    exp_cmd.delete();
    exp_data.delete();
    exp_end.delete();
    @(negedge sys_clk);
    check("abort_outputs", 64'({read_cmd, read_ba, read_addr, rd_ack, rd_sdram_data}),
          64'({4'b0111, 2'b11, 13'h1fff, 1'b0, 16'h0000}));
    @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);

    // Fresh request after the abort starts again from ACTIVE.
    run_burst(24'h800A05, 10'd2, 2, 16'h3300, 2'd2, 13'h0005, 13'h0005, 1'b1);

    repeat (5) @(posedge sys_clk);
    @(negedge sys_clk);
    check("cmd_queue_drained", 64'(exp_cmd.size()), 64'(0));
    check("data_queue_drained", 64'(exp_data.size()), 64'(0));
    check("end_queue_drained", 64'(exp_end.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
